ltc2333_multi_reader: RTL

LTC2333_MULTI_READER -- requirements
Module: ltc2333_multi_reader

---
 rtl/ltc2333_pkg.sv | 26 ++
 rtl/ltc2333_lane_capture.sv | 72 +++++++
 rtl/ltc2333_multi_reader.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ltc2333_pkg.sv
// Shared definitions for the LTC2333 multi-lane reader: readout FSM state
// encoding, default parameter values and the drain timeout length.
package ltc2333_pkg;

    localparam int LTC_NUM_LANES   = 8;
    localparam int LTC_FRAME_BITS  = 24;
    localparam int LTC_CONV_CYCLES = 64;
    localparam int LTC_SCK_HALF    = 2;

    // Width of the general-purpose phase/conversion/drain counter.
    localparam int LTC_CNT_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CONV  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DRAIN = 2'd3
    } state_e;

    // Drain window: long enough for the last echoed scko edge to cross the
    // two-flop synchroniser with a comfortable margin.
    function automatic int ltc_timeout_cycles(input int sck_half);
        return 4 * sck_half + 8;
    endfunction

endpackage

// File: rtl/ltc2333_lane_capture.sv
// One LTC2333 readout lane: synchronises the echoed scko and sdo into the
// ACLK domain, detects scko rising edges and shifts sdo in MSB-first until a
// full frame has been collected.
module ltc2333_lane_capture
    import ltc2333_pkg::*;
#(
    parameter int FRAME_BITS = LTC_FRAME_BITS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  scko,
    input  logic                  sdo,
    output logic [FRAME_BITS-1:0] data,
    output logic                  done
);

    localparam int BIT_W = $clog2(FRAME_BITS + 1);

    logic [1:0]            scko_sync_q, scko_sync_d;
    logic [1:0]            sdo_sync_q,  sdo_sync_d;
    logic                  scko_prev_q, scko_prev_d;
    logic [FRAME_BITS-1:0] shift_q,     shift_d;
    logic [BIT_W-1:0]      bit_cnt_q,   bit_cnt_d;
    logic                  scko_rise;

    // scko and sdo use identical sync depth so the sampled bit stays aligned
    // with the detected edge.
    assign scko_rise = scko_sync_q[1] & ~scko_prev_q;
    assign done      = (bit_cnt_q == BIT_W'(FRAME_BITS));
    assign data      = shift_q;

    // Next-state: sync chains, edge history, shift register and bit count.
    always_comb begin
        // NOTE: every combinational output is given a default first, so no
        // path leaves it unassigned and no latch is inferred.
        // NOTE: combinational logic uses blocking '='; only the always_ff
        // below uses non-blocking '<='.
        scko_sync_d = {scko_sync_q[0], scko};
        sdo_sync_d  = {sdo_sync_q[0], sdo};
        scko_prev_d = scko_sync_q[1];
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        if (clear) begin
            shift_d   = '0;
            bit_cnt_d = '0;
        end else if (scko_rise && !done) begin
            shift_d   = {shift_q[FRAME_BITS-2:0], sdo_sync_q[1]};
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
        end
    end

    // Lane state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scko_sync_q <= '0;
            sdo_sync_q  <= '0;
            scko_prev_q <= 1'b0;
            // NOTE: the data shift register is reset as well as the control
            // bits, since its contents are visible on m_data after a frame.
            shift_q     <= '0;
            bit_cnt_q   <= '0;
        end else begin
            scko_sync_q <= scko_sync_d;
            sdo_sync_q  <= sdo_sync_d;
            scko_prev_q <= scko_prev_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
        end
    end

endmodule

// File: rtl/ltc2333_multi_reader.sv
// Parallel reader for NUM_LANES LTC2333 ADCs sharing cnv/scki/sdi. One
// conversion: pulse cnv, wait CONV_CYCLES, clock out FRAME_BITS of cfg_word
// on sdi while each lane captures its echoed frame, then publish all lanes
// on a valid/ready stream. Frames that arrive while the previous result is
// still unaccepted are dropped and counted in ovf_cnt.
// Build option: define LTC_READOUT_TIMEOUT_EN to bound the drain wait; lanes
// that have not delivered a full frame by then are flagged in lane_err and
// their field is zeroed.
module ltc2333_multi_reader
    import ltc2333_pkg::*;
#(
    parameter int NUM_LANES   = LTC_NUM_LANES,
    parameter int FRAME_BITS  = LTC_FRAME_BITS,
    parameter int CONV_CYCLES = LTC_CONV_CYCLES,
    parameter int SCK_HALF    = LTC_SCK_HALF
) (
    input  logic                            ACLK,
    input  logic                            ARESETn,
    input  logic                            start,
    input  logic                            continuous,
    input  logic [FRAME_BITS-1:0]           cfg_word,
    output logic                            cnv,
    output logic                            scki,
    output logic                            sdi,
    input  logic [NUM_LANES-1:0]            scko,
    input  logic [NUM_LANES-1:0]            sdo,
    output logic                            m_valid,
    input  logic                            m_ready,
    output logic [NUM_LANES*FRAME_BITS-1:0] m_data,
    output logic                            busy,
    output logic [NUM_LANES-1:0]            lane_err,
    output logic [15:0]                     ovf_cnt
);

    localparam int CNT_W = LTC_CNT_W;
    localparam int BIT_W = $clog2(FRAME_BITS + 1);
`ifdef LTC_READOUT_TIMEOUT_EN
    localparam int TIMEOUT_CYCLES = ltc_timeout_cycles(SCK_HALF);
`endif

    state_e                         state_q, state_d;
    logic [CNT_W-1:0]               cnt_q, cnt_d;
    logic [BIT_W-1:0]               bit_cnt_q, bit_cnt_d;
    logic [FRAME_BITS-1:0]          cfg_q, cfg_d;
    logic                           cnv_q, cnv_d;
    logic                           scki_q, scki_d;
    logic                           sdi_q, sdi_d;
    logic                           m_valid_q, m_valid_d;
    logic [NUM_LANES*FRAME_BITS-1:0] m_data_q, m_data_d;
    logic [15:0]                    ovf_q, ovf_d;

    logic                                  lane_clear;
    logic                                  frame_done;
    logic                                  all_done;
    logic [NUM_LANES-1:0]                  lane_done;
    logic [NUM_LANES-1:0][FRAME_BITS-1:0]  lane_data;
    logic [NUM_LANES-1:0][FRAME_BITS-1:0]  frame_data;

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        ltc2333_lane_capture #(
            .FRAME_BITS (FRAME_BITS)
        ) u_lane (
            .clk   (ACLK),
            .rst_n (ARESETn),
            .clear (lane_clear),
            .scko  (scko[g]),
            .sdo   (sdo[g]),
            .data  (lane_data[g]),
            .done  (lane_done[g])
        );
    end

    assign all_done = &lane_done;
    assign cnv      = cnv_q;
    assign scki     = scki_q;
    assign sdi      = sdi_q;
    assign m_valid  = m_valid_q;
    assign m_data   = m_data_q;
    assign ovf_cnt  = ovf_q;
    assign busy     = (state_q != ST_IDLE);

    // Readout sequencer: trigger, conversion wait, scki/sdi generation, drain.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_cnt_d  = bit_cnt_q;
        cfg_d      = cfg_q;
        cnv_d      = 1'b0;
        scki_d     = scki_q;
        sdi_d      = sdi_q;
        lane_clear = 1'b0;
        frame_done = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                // start is only looked at here, so a start while busy is lost.
                if (start || continuous) begin
                    cfg_d      = cfg_word;
                    cnv_d      = 1'b1;
                    lane_clear = 1'b1;
                    cnt_d      = '0;
                    state_d    = ST_CONV;
                end
            end
            ST_CONV: begin
                if (cnt_q == CNT_W'(CONV_CYCLES - 1)) begin
                    // Present the MSB a full low phase before the first edge.
                    cnt_d     = '0;
                    bit_cnt_d = '0;
                    scki_d    = 1'b0;
                    sdi_d     = cfg_q[FRAME_BITS-1];
                    state_d   = ST_SHIFT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_SHIFT: begin
                if (cnt_q == CNT_W'(SCK_HALF - 1)) begin
                    cnt_d  = '0;
                    scki_d = ~scki_q;
                    if (scki_q) begin
                        // Falling edge: advance sdi, or end after the last pulse.
                        cfg_d = {cfg_q[FRAME_BITS-2:0], 1'b0};
                        if (bit_cnt_q == BIT_W'(FRAME_BITS - 1)) begin
                            sdi_d   = 1'b0;
                            state_d = ST_DRAIN;
                        end else begin
                            sdi_d     = cfg_q[FRAME_BITS-2];
                            bit_cnt_d = bit_cnt_q + BIT_W'(1);
                        end
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DRAIN: begin
`ifdef LTC_READOUT_TIMEOUT_EN
                if (all_done || (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1))) begin
                    frame_done = 1'b1;
                    cnt_d      = '0;
                    state_d    = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`else
                if (all_done) begin
                    frame_done = 1'b1;
                    state_d    = ST_IDLE;
                end
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Assemble the published frame; lane 0 lands in the LSBs.
    always_comb begin
        frame_data = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
`ifdef LTC_READOUT_TIMEOUT_EN
            frame_data[i] = lane_done[i] ? lane_data[i] : '0;
`else
            frame_data[i] = lane_data[i];
`endif
        end
    end

    // Output stream: load when free or being accepted this cycle, else drop.
    always_comb begin
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        ovf_d     = ovf_q;
        if (frame_done) begin
            if (!m_valid_q || m_ready) begin
                m_valid_d = 1'b1;
                m_data_d  = frame_data;
            end else if (ovf_q != 16'hFFFF) begin
                ovf_d = ovf_q + 16'd1;
            end
        end else if (m_valid_q && m_ready) begin
            m_valid_d = 1'b0;
        end
    end

    // FSM state register.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Sequencer counters, ADC control lines and output stream registers.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            cfg_q     <= '0;
            cnv_q     <= 1'b0;
            scki_q    <= 1'b0;
            sdi_q     <= 1'b0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            ovf_q     <= '0;
        end else begin
            cnt_q     <= cnt_d;
            bit_cnt_q <= bit_cnt_d;
            cfg_q     <= cfg_d;
            cnv_q     <= cnv_d;
            scki_q    <= scki_d;
            sdi_q     <= sdi_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            ovf_q     <= ovf_d;
        end
    end

`ifdef LTC_READOUT_TIMEOUT_EN
    logic [NUM_LANES-1:0] lane_err_q, lane_err_d;

    // Sticky per-lane error: set for every lane missing at frame completion.
    always_comb begin
        lane_err_d = lane_err_q;
        if (frame_done) begin
            lane_err_d = lane_err_q | ~lane_done;
        end
    end

    // Lane error register.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            lane_err_q <= '0;
        end else begin
            lane_err_q <= lane_err_d;
        end
    end

    assign lane_err = lane_err_q;
`else
    assign lane_err = '0;
`endif

endmodule
